async_transmitter_param: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8-bit odd-parity transmitter. It serialises words of configurable width with runtime-selectable parity and stop-bit count, and buffers writes in an optional TX FIFO. It sits between a byte-producing core and the board TxD pin, and shares its frame format with the existing UART receive path.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/async_transmitter_param.sv | 211 +++++++++++++++++++++
 tb/tb_async_transmitter_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive paths.
// Parity mode codes, transmitter FSM encoding and the baud divider helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer with show-ahead read data.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/async_transmitter_param.sv
// async_transmitter_param: parametrised UART transmitter with parity/stop options.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise one holding register.
module async_transmitter_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 19200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          TxD_start,
    input  logic [DATA_BITS-1:0]          TxD_data,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          TxD_ready,
    output logic                          TxD,
    output logic                          TxD_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_overflow
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV + 1);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    logic                 wr;
    logic                 pop;
    logic                 buf_full;
    logic                 buf_empty;
    logic [DATA_BITS-1:0] buf_data;
    logic [LW-1:0]        buf_level;

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
    logic                 tick;
    logic                 load;

    assign TxD_ready  = !buf_full;
    assign wr         = TxD_start && TxD_ready;
    assign tick       = (div_q == CW'(DIV - 1));
    assign TxD        = txd_q;
    assign TxD_busy   = (state_q != IDLE) || !buf_empty;
    assign fifo_level = buf_level;

`ifdef UART_TX_FIFO_EN
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data (TxD_data),
        .rd_en   (pop),
        .rd_data (buf_data),
        .full    (buf_full),
        .empty   (buf_empty),
        .level   (buf_level)
    );
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_v;

    // Single-entry holding register; write and pop never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            hold_v <= 1'b0;
        end else if (wr) begin
            hold_q <= TxD_data;
            hold_v <= 1'b1;
        end else if (pop) begin
            hold_v <= 1'b0;
        end
    end

    assign buf_full  = hold_v;
    assign buf_empty = !hold_v;
    assign buf_data  = hold_q;
    assign buf_level = {{(LW-1){1'b0}}, hold_v};
`endif

    // Sticky flag for writes dropped against a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_overflow <= 1'b0;
        else if (TxD_start && !TxD_ready) tx_overflow <= 1'b1;
    end

    // Frame state and line register; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
        end
    end

    // Next-state, next line value and frame option latch at pop.
    always_comb begin
        state_d  = state_q;
        div_d    = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        txd_d    = txd_q;
        load     = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!buf_empty) load = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop2_q && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else if (!buf_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                        bit_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            state_d = START;
            txd_d   = 1'b0;
            sh_d    = buf_data;
            bit_d   = '0;
            stop2_d = stop2;
            unique case (parity_mode)
                PAR_EVEN: begin
                    par_en_d = 1'b1;
                    par_d    = ^buf_data;
                end
                PAR_ODD: begin
                    par_en_d = 1'b1;
                    par_d    = ~^buf_data;
                end
                PAR_NONE: begin
                    par_en_d = 1'b0;
                    par_d    = 1'b0;
                end
                default: begin
                    par_en_d = 1'b0;
                    par_d    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_transmitter_param.sv
// tb_async_transmitter_param: table vectors plus frame scoreboard for the UART TX.
// Small divider (300 kHz / 19200 -> 16, exercises rounding) keeps frames short.
`timescale 1ns/1ps
module tb_async_transmitter_param;

    localparam int CLK_FREQ = 300000;
    localparam int BAUD     = 19200;
    localparam int DIV      = 16;

`ifdef UART_TX_FIFO_EN
    localparam logic RDY1    = 1'b1;
    localparam int   NBURST  = 5;
    localparam int   LVLPEAK = 4;
`else
    localparam logic RDY1    = 1'b0;
    localparam int   NBURST  = 2;
    localparam int   LVLPEAK = 1;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       s2;
        bit         hp;
        logic       p;
        int         len;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       st8, s28, rdy8, txd8, busy8, ovf8;
    logic [7:0] d8;
    logic [1:0] pm8;
    logic [2:0] lvl8;
    logic       st5, s25, rdy5, txd5, busy5, ovf5;
    logic [4:0] d5;
    logic [1:0] pm5;
    logic [4:0] lvl5;

    int     nvec;
    int     nerr;
    int     cyc;
    frame_t sb[$];

    async_transmitter_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(4)
    ) u8 (
        .clk(clk), .rst_n(rst_n), .TxD_start(st8), .TxD_data(d8),
        .parity_mode(pm8), .stop2(s28), .TxD_ready(rdy8), .TxD(txd8),
        .TxD_busy(busy8), .fifo_level(lvl8), .tx_overflow(ovf8)
    );

    async_transmitter_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(5), .FIFO_DEPTH(16)
    ) u5 (
        .clk(clk), .rst_n(rst_n), .TxD_start(st5), .TxD_data(d5),
        .parity_mode(pm5), .stop2(s25), .TxD_ready(rdy5), .TxD(txd5),
        .TxD_busy(busy5), .fifo_level(lvl5), .tx_overflow(ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: at a negedge it holds the count of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t mk(input logic [7:0] d, input int nb,
                                  input bit hp, input logic p, input int len);
        frame_t f;
        f.data = d;
        f.bits = '1;
        f.len  = len;
        f.bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) f.bits[1+i] = d[i];
        if (hp) f.bits[1+nb] = p;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr8(input logic [7:0] d, input logic [1:0] m, input logic s2);
        d8  = d;
        pm8 = m;
        s28 = s2;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget, output int t);
        int n;
        n = 0;
        while ((busy8 !== 1'b0 || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (n >= budget) begin
            nvec++;
            nerr++;
            $display("FAIL %s: timeout, busy %b queued %0d, expected idle", nm, busy8, sb.size());
        end
    endtask

    task automatic run5(input logic [4:0] d, input logic [1:0] m, input logic s2,
                        input bit hp, input logic p, input int len);
        frame_t f;
        int bad;
        f = mk({3'b000, d}, 5, hp, p, len);
        d5  = d;
        pm5 = m;
        s25 = s2;
        st5 = 1'b1;
        @(negedge clk);
        st5 = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < len * DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (txd5 !== f.bits[k/DIV] || busy5 !== 1'b1) bad++;
        end
        @(negedge clk);
        chk($sformatf("w5_%02h_wave_badcycles", d), bad, 0);
        chk($sformatf("w5_%02h_busy_end", d), busy5, 0);
    endtask

    // Frame monitor: pops an expected frame at each start bit, checks every cycle.
    initial begin : mon
        frame_t      f;
        int          bad;
        logic [11:0] got;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd8 === 1'b0 && sb.size() > 0) begin
                f   = sb.pop_front();
                bad = 0;
                got = '1;
                for (int k = 0; k < f.len * DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    if (txd8 !== f.bits[k/DIV]) bad++;
                    if (k % DIV == DIV / 2) got[k/DIV] = txd8;
                end
                nvec++;
                if (bad != 0) begin
                    nerr++;
                    $display("FAIL frame_%02h: %0d bad cycles, got bits %b expected %b",
                             f.data, bad, got, f.bits);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       tbl [8];
        logic [7:0] bw  [6];
        logic       bp  [6];
        bit         acc [6];
        int         tw;
        int         t;
        int         bad;

        nvec = 0;
        nerr = 0;
        cyc  = 0;
        rst_n = 1'b0;
        st8 = 1'b0; d8 = '0; pm8 = '0; s28 = 1'b0;
        st5 = 1'b0; d5 = '0; pm5 = '0; s25 = 1'b0;

        tbl[0] = '{8'hA5, 2'b10, 1'b0, 1'b1, 1'b1, 11};
        tbl[1] = '{8'h07, 2'b01, 1'b1, 1'b1, 1'b1, 12};
        tbl[2] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 10};
        tbl[3] = '{8'h80, 2'b11, 1'b1, 1'b0, 1'b0, 11};
        tbl[4] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b1, 12};
        tbl[5] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 11};
        tbl[6] = '{8'h5A, 2'b10, 1'b0, 1'b1, 1'b1, 11};
        tbl[7] = '{8'hE9, 2'b01, 1'b1, 1'b1, 1'b1, 12};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_txd", txd8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_ready", rdy8, 1);
        chk("rst_level", lvl8, 0);
        chk("rst_overflow", ovf8, 0);
        chk("rst_txd5", txd5, 1);
        chk("rst_ready5", rdy5, 1);

        for (int i = 0; i < 8; i++) begin
            wr8(tbl[i].d, tbl[i].m, tbl[i].s2);
            tw = cyc;
            sb.push_back(mk(tbl[i].d, 8, tbl[i].hp, tbl[i].p, tbl[i].len));
            if (i == 0) begin
                chk("lat_txd_at_write", txd8, 1);
                chk("lat_busy_at_write", busy8, 1);
                chk("lat_level_at_write", lvl8, 1);
                chk("lat_ready_at_write", rdy8, RDY1);
                @(negedge clk);
                chk("lat_txd_next_edge", txd8, 0);
                chk("lat_level_next_edge", lvl8, 0);
            end
            wait_idle($sformatf("vec%0d_idle", i), 40 * DIV, t);
            chk($sformatf("vec%0d_duration", i), t - tw, 1 + tbl[i].len * DIV);
        end
        chk("overflow_clear", ovf8, 0);

        run5(5'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 7);
        run5(5'h16, 2'b10, 1'b1, 1'b1, 1'b0, 9);
        run5(5'h0A, 2'b01, 1'b0, 1'b1, 1'b0, 8);
        chk("overflow5_clear", ovf5, 0);

        wr8(8'h5A, 2'b10, 1'b0);
        tw = cyc;
        sb.push_back(mk(8'h5A, 8, 1'b1, 1'b1, 11));
        sb.push_back(mk(8'h5A, 8, 1'b1, 1'b0, 11));
        repeat (3 * DIV) @(negedge clk);
        wr8(8'h5A, 2'b01, 1'b0);
        wait_idle("cfg_idle", 60 * DIV, t);
        chk("cfg_duration", t - tw, 1 + 22 * DIV);

        bw = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
        bp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef UART_TX_FIFO_EN
        acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        acc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 6; i++)
            if (acc[i]) sb.push_back(mk(bw[i], 8, 1'b1, bp[i], 11));
        tw = 0;
        for (int i = 0; i < 6; i++) begin
            wr8(bw[i], 2'b01, 1'b0);
            if (i == 0) tw = cyc;
        end
        chk("burst_overflow", ovf8, 1);
        chk("burst_ready", rdy8, 0);
        chk("burst_level", lvl8, LVLPEAK);
        wait_idle("burst_idle", 150 * DIV, t);
        chk("burst_duration", t - tw, 1 + NBURST * 11 * DIV);

        wr8(8'hC3, 2'b10, 1'b0);
        repeat (DIV) @(negedge clk);
        wr8(8'h96, 2'b10, 1'b0);
        chk("mid_level_before_reset", lvl8, 1);
        repeat (3 * DIV + DIV / 2) @(negedge clk);
        chk("mid_txd_data_bit3", txd8, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_txd", txd8, 1);
        chk("mid_reset_level", lvl8, 0);
        chk("mid_reset_busy", busy8, 0);
        chk("mid_reset_overflow", ovf8, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20 * DIV; k++) begin
            @(negedge clk);
            if (txd8 !== 1'b1 || busy8 !== 1'b0) bad++;
        end
        chk("post_reset_quiet_badcycles", bad, 0);
        chk("post_reset_ready", rdy8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
